// File: rtl/hazard_ctrl_pkg.sv
// Shared codes for the hazard controller: FSM states, forward selects and
// register write modes (NOREGWRITE marks an instruction that writes no register).
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'b00,
        ST_RUN   = 2'b01,
        ST_MISS  = 2'b10
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Combinational forward select for one EX operand; MEM result wins over WB,
// and x0 is never forwarded.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       read_en,
    input  logic [4:0] dst_m,
    input  logic [2:0] write_m,
    input  logic [4:0] dst_w,
    input  logic [2:0] write_w,
    output logic [1:0] sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = read_en && (write_m != NOREGWRITE) && (dst_m != 5'd0) && (dst_m == src);
    assign hit_w = read_en && (write_w != NOREGWRITE) && (dst_w != 5'd0) && (dst_w == src);

    always_comb begin
        sel = FWD_REG;
        if (hit_m)
            sel = FWD_MEM;
        else if (hit_w)
            sel = FWD_WB;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: post-reset flush, cache-miss freeze, branch/load-use/JAL
// handling and EX forwarding. Define HAZARD_PERF_CNT_EN to build the performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RST_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Reg1SrcD,
    input  logic [4:0]  Reg2SrcD,
    input  logic [1:0]  RegReadD,
    input  logic [4:0]  Reg1SrcE,
    input  logic [4:0]  Reg2SrcE,
    input  logic [1:0]  RegReadE,
    input  logic [4:0]  RegDstE,
    input  logic [4:0]  RegDstM,
    input  logic [4:0]  RegDstW,
    input  logic        MemToRegE,
    input  logic [2:0]  RegWriteM,
    input  logic [2:0]  RegWriteW,
    input  logic        BranchE,
    input  logic        JalrE,
    input  logic        JalD,
    input  logic        ICacheMiss,
    input  logic        DCacheMiss,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushF,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic [1:0]  Forward1E,
    output logic [1:0]  Forward2E,
    output logic [31:0] StallCnt,
    output logic [31:0] LoadUseCnt,
    output logic [31:0] FlushCnt
);

    localparam logic [3:0] FLUSH_RELOAD = 4'(RST_FLUSH_CYCLES);

    state_t     state;
    state_t     state_next;
    logic [3:0] flush_cnt;
    logic [1:0] fwd1;
    logic [1:0] fwd2;
    logic       any_miss;
    logic       redirect;
    logic       load_use;

    assign any_miss = ICacheMiss | DCacheMiss;
    assign redirect = BranchE | JalrE;
    assign load_use = MemToRegE && (RegDstE != 5'd0) &&
                      (((RegDstE == Reg1SrcD) && RegReadD[1]) ||
                       ((RegDstE == Reg2SrcD) && RegReadD[0]));

    hazard_fwd_sel u_fwd1 (
        .src(Reg1SrcE), .read_en(RegReadE[1]),
        .dst_m(RegDstM), .write_m(RegWriteM),
        .dst_w(RegDstW), .write_w(RegWriteW),
        .sel(fwd1)
    );

    hazard_fwd_sel u_fwd2 (
        .src(Reg2SrcE), .read_en(RegReadE[0]),
        .dst_m(RegDstM), .write_m(RegWriteM),
        .dst_w(RegDstW), .write_w(RegWriteW),
        .sel(fwd2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_RELOAD;
        end else begin
            state <= state_next;
            if (state == ST_FLUSH)
                flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // RUN and MISS share one decode: MISS only persists while a miss is still high.
    always_comb begin
        state_next = state;
        {StallF, StallD, StallE, StallM, StallW} = 5'b00000;
        {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b00000;
        Forward1E = FWD_REG;
        Forward2E = FWD_REG;
        case (state)
            ST_FLUSH: begin
                {FlushF, FlushD, FlushE, FlushM, FlushW} = 5'b11111;
                if (flush_cnt == 4'd1)
                    state_next = ST_RUN;
            end
            ST_RUN, ST_MISS: begin
                Forward1E  = fwd1;
                Forward2E  = fwd2;
                state_next = ST_RUN;
                if (any_miss) begin
                    {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
                    state_next = ST_MISS;
                end else if (redirect) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (JalD) begin
                    FlushD = 1'b1;
                end
            end
            default: state_next = ST_FLUSH;
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // StallW is only raised by a miss and StallF without StallW only by load-use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt   <= 32'd0;
            LoadUseCnt <= 32'd0;
            FlushCnt   <= 32'd0;
        end else begin
            if (StallW)
                StallCnt <= sat_inc(StallCnt);
            if (StallF && !StallW)
                LoadUseCnt <= sat_inc(LoadUseCnt);
            if (FlushE && (state != ST_FLUSH))
                FlushCnt <= sat_inc(FlushCnt);
        end
    end
`else
    assign StallCnt   = 32'd0;
    assign LoadUseCnt = 32'd0;
    assign FlushCnt   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with RST_FLUSH_CYCLES=2; counter expectations
// follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Reg1SrcD, Reg2SrcD, Reg1SrcE, Reg2SrcE;
    logic [1:0]  RegReadD, RegReadE;
    logic [4:0]  RegDstE, RegDstM, RegDstW;
    logic        MemToRegE;
    logic [2:0]  RegWriteM, RegWriteW;
    logic        BranchE, JalrE, JalD, ICacheMiss, DCacheMiss;
    logic        StallF, StallD, StallE, StallM, StallW;
    logic        FlushF, FlushD, FlushE, FlushM, FlushW;
    logic [1:0]  Forward1E, Forward2E;
    logic [31:0] StallCnt, LoadUseCnt, FlushCnt;
    logic [4:0]  stall_v, flush_v;

    int checks = 0;
    int errors = 0;

    assign stall_v = {StallF, StallD, StallE, StallM, StallW};
    assign flush_v = {FlushF, FlushD, FlushE, FlushM, FlushW};

    always #5 clk = ~clk;

    hazard_ctrl #(.RST_FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .Reg1SrcD(Reg1SrcD), .Reg2SrcD(Reg2SrcD), .RegReadD(RegReadD),
        .Reg1SrcE(Reg1SrcE), .Reg2SrcE(Reg2SrcE), .RegReadE(RegReadE),
        .RegDstE(RegDstE), .RegDstM(RegDstM), .RegDstW(RegDstW),
        .MemToRegE(MemToRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .BranchE(BranchE), .JalrE(JalrE), .JalD(JalD),
        .ICacheMiss(ICacheMiss), .DCacheMiss(DCacheMiss),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushF(FlushF), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .Forward1E(Forward1E), .Forward2E(Forward2E),
        .StallCnt(StallCnt), .LoadUseCnt(LoadUseCnt), .FlushCnt(FlushCnt)
    );

    task automatic clear_inputs();
        Reg1SrcD = 0; Reg2SrcD = 0; RegReadD = 0;
        Reg1SrcE = 0; Reg2SrcE = 0; RegReadE = 0;
        RegDstE = 0; RegDstM = 0; RegDstW = 0;
        MemToRegE = 0; RegWriteM = NOREGWRITE; RegWriteW = NOREGWRITE;
        BranchE = 0; JalrE = 0; JalD = 0; ICacheMiss = 0; DCacheMiss = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        RegDstM = 5'd3; RegWriteM = LW; Reg2SrcE = 5'd3; RegReadE = 2'b01;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (flush_v !== 5'b11111) begin errors++; $display("FAIL rst_flush got %b want %b", flush_v, 5'b11111); end
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("FAIL rst_stall got %b want %b", stall_v, 5'b00000); end
        checks++; if (Forward2E !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b want %b", Forward2E, 2'b00); end
        checks++; if (StallCnt !== 32'd0 || FlushCnt !== 32'd0 || LoadUseCnt !== 32'd0) begin
            errors++; $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0", StallCnt, LoadUseCnt, FlushCnt); end
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (flush_v !== 5'b11111) begin errors++; $display("FAIL flush_e0 got %b want %b", flush_v, 5'b11111); end
        @(negedge clk); #1;
        checks++; if (flush_v !== 5'b11111) begin errors++; $display("FAIL flush_e1 got %b want %b", flush_v, 5'b11111); end
        checks++; if (Forward2E !== 2'b00) begin errors++; $display("FAIL flush_fwd got %b want %b", Forward2E, 2'b00); end
        @(negedge clk); #1;
        checks++; if (flush_v !== 5'b00000) begin errors++; $display("FAIL flush_e2 got %b want %b", flush_v, 5'b00000); end
        checks++; if (Forward2E !== 2'b10) begin errors++; $display("FAIL run_fwd got %b want %b", Forward2E, 2'b10); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        clear_inputs();
        RegDstM = 5'd3; RegDstW = 5'd3; RegWriteM = LW; RegWriteW = LW;
        Reg2SrcE = 5'd3; RegReadE = 2'b01;
        #1;
        checks++; if (Forward2E !== 2'b10) begin errors++; $display("FAIL fwd_mem got %b want %b", Forward2E, 2'b10); end
        checks++; if (Forward1E !== 2'b00) begin errors++; $display("FAIL fwd1_idle got %b want %b", Forward1E, 2'b00); end
        @(negedge clk) RegWriteM = NOREGWRITE;
        #1;
        checks++; if (Forward2E !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b want %b", Forward2E, 2'b01); end
        @(negedge clk) RegReadE = 2'b00;
        #1;
        checks++; if (Forward2E !== 2'b00) begin errors++; $display("FAIL fwd_noread got %b want %b", Forward2E, 2'b00); end
        @(negedge clk) begin RegWriteM = LW; Reg1SrcE = 5'd3; RegReadE = 2'b10; end
        #1;
        checks++; if (Forward1E !== 2'b10 || Forward2E !== 2'b00) begin
            errors++; $display("FAIL fwd1_mem got %b/%b want 10/00", Forward1E, Forward2E); end
        @(negedge clk) begin RegDstM = 0; RegDstW = 0; Reg1SrcE = 0; end
        #1;
        checks++; if (Forward1E !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b want %b", Forward1E, 2'b00); end
        checks++; if (flush_v !== 5'b00000 || stall_v !== 5'b00000) begin
            errors++; $display("FAIL fwd_quiet got %b/%b want 00000/00000", stall_v, flush_v); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        MemToRegE = 1; RegDstE = 5'd5; Reg1SrcD = 5'd5; RegReadD = 2'b10;
        #1;
        checks++; if (stall_v !== 5'b11000) begin errors++; $display("FAIL lu_stall got %b want %b", stall_v, 5'b11000); end
        checks++; if (flush_v !== 5'b00100) begin errors++; $display("FAIL lu_flush got %b want %b", flush_v, 5'b00100); end
        @(negedge clk) MemToRegE = 0;
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b00000) begin
            errors++; $display("FAIL lu_once got %b/%b want 00000/00000", stall_v, flush_v); end
        @(negedge clk) begin MemToRegE = 1; RegDstE = 5'd0; Reg1SrcD = 5'd0; end
        #1;
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("FAIL lu_x0 got %b want %b", stall_v, 5'b00000); end
        @(negedge clk) begin RegDstE = 5'd7; Reg1SrcD = 5'd7; RegReadD = 2'b01; end
        #1;
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("FAIL lu_unused got %b want %b", stall_v, 5'b00000); end
        @(negedge clk) begin Reg1SrcD = 5'd1; Reg2SrcD = 5'd7; end
        #1;
        checks++; if (stall_v !== 5'b11000 || flush_v !== 5'b00100) begin
            errors++; $display("FAIL lu_rs2 got %b/%b want 11000/00100", stall_v, flush_v); end
    endtask

    task automatic test_branch_priority();
        @(negedge clk);
        clear_inputs();
        BranchE = 1; JalD = 1; MemToRegE = 1; RegDstE = 5'd5; Reg1SrcD = 5'd5; RegReadD = 2'b10;
        #1;
        checks++; if (flush_v !== 5'b01100) begin errors++; $display("FAIL br_flush got %b want %b", flush_v, 5'b01100); end
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("FAIL br_stall got %b want %b", stall_v, 5'b00000); end
        @(negedge clk);
        clear_inputs();
        JalrE = 1;
        #1;
        checks++; if (flush_v !== 5'b01100) begin errors++; $display("FAIL jalr_flush got %b want %b", flush_v, 5'b01100); end
        @(negedge clk) begin JalrE = 0; JalD = 1; end
        #1;
        checks++; if (flush_v !== 5'b01000) begin errors++; $display("FAIL jal_flush got %b want %b", flush_v, 5'b01000); end
        @(negedge clk) JalD = 0;
        #1;
        checks++; if (LoadUseCnt !== (PERF ? 32'd2 : 32'd0)) begin
            errors++; $display("FAIL lu_cnt got %0d want %0d", LoadUseCnt, PERF ? 2 : 0); end
        checks++; if (FlushCnt !== (PERF ? 32'd4 : 32'd0)) begin
            errors++; $display("FAIL flush_cnt got %0d want %0d", FlushCnt, PERF ? 4 : 0); end
    endtask

    task automatic test_miss();
        @(negedge clk);
        clear_inputs();
        DCacheMiss = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++; if (stall_v !== 5'b11111 || flush_v !== 5'b00000) begin
                errors++; $display("FAIL miss_c%0d got %b/%b want 11111/00000", i, stall_v, flush_v); end
        end
        @(negedge clk) DCacheMiss = 0;
        #1;
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("FAIL miss_end got %b want %b", stall_v, 5'b00000); end
        checks++; if (StallCnt !== (PERF ? 32'd4 : 32'd0)) begin
            errors++; $display("FAIL stall_cnt got %0d want %0d", StallCnt, PERF ? 4 : 0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk) DCacheMiss = 1;
        #1;
        checks++; if (stall_v !== 5'b11111) begin errors++; $display("FAIL b2b_m1 got %b want %b", stall_v, 5'b11111); end
        @(negedge clk) begin DCacheMiss = 0; JalD = 1; end
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b01000) begin
            errors++; $display("FAIL b2b_gap got %b/%b want 00000/01000", stall_v, flush_v); end
        @(negedge clk) begin ICacheMiss = 1; JalD = 0; end
        #1;
        checks++; if (stall_v !== 5'b11111) begin errors++; $display("FAIL b2b_m2 got %b want %b", stall_v, 5'b11111); end
        @(negedge clk) ICacheMiss = 0;
        #1;
        checks++; if (StallCnt !== (PERF ? 32'd6 : 32'd0)) begin
            errors++; $display("FAIL b2b_cnt got %0d want %0d", StallCnt, PERF ? 6 : 0); end
    endtask

    task automatic test_rst_in_miss();
        @(negedge clk) ICacheMiss = 1;
        @(negedge clk); #1;
        checks++; if (stall_v !== 5'b11111) begin errors++; $display("FAIL rim_miss got %b want %b", stall_v, 5'b11111); end
        rst = 1'b1;
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b11111) begin
            errors++; $display("FAIL rim_async got %b/%b want 00000/11111", stall_v, flush_v); end
        checks++; if (StallCnt !== 32'd0) begin errors++; $display("FAIL rim_cnt got %0d want 0", StallCnt); end
        @(negedge clk) rst = 1'b0;
        #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b11111) begin
            errors++; $display("FAIL rim_f0 got %b/%b want 00000/11111", stall_v, flush_v); end
        @(negedge clk); #1;
        checks++; if (stall_v !== 5'b00000 || flush_v !== 5'b11111) begin
            errors++; $display("FAIL rim_f1 got %b/%b want 00000/11111", stall_v, flush_v); end
        @(negedge clk); #1;
        checks++; if (stall_v !== 5'b11111 || flush_v !== 5'b00000) begin
            errors++; $display("FAIL rim_run got %b/%b want 11111/00000", stall_v, flush_v); end
        @(negedge clk) ICacheMiss = 0;
        #1;
        checks++; if (stall_v !== 5'b00000) begin errors++; $display("FAIL rim_end got %b want %b", stall_v, 5'b00000); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch_priority();
        test_miss();
        test_back_to_back();
        test_rst_in_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
